// File: rtl/branch_training_scheduler.sv
// branch_training_scheduler: in-order in-flight branch queue that feeds the predictor
// training port one update per cycle. Optional stats counters under `BTS_STATS_EN.
module branch_training_scheduler #(
  parameter int DEPTH = 8,
  parameter int PCW   = 32,
  localparam int TW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           predValid,
  input  logic [PCW-1:0] predPC,
  input  logic           predTaken,
  input  logic [2:0]     predType,
  output logic           predReady,
  output logic [TW-1:0]  predTag,
  input  logic           resValid,
  input  logic [TW-1:0]  resTag,
  input  logic           resTaken,
  output logic           trainValid,
  output logic [PCW-1:0] trainPC,
  output logic           trainTaken,
  output logic [2:0]     trainType,
  output logic           trainPredicted,
  output logic           mispredict,
  output logic [TW-1:0]  mispredictTag,
  output logic [TW:0]    occupancy,
  output logic [15:0]    statTrained,
  output logic [15:0]    statMispredicts
);

  localparam logic [TW:0] FULL_OCC = (TW+1)'(DEPTH);
  localparam logic [TW:0] PTR_ONE  = (TW+1)'(1);

  logic [DEPTH-1:0] valid_r, resolved_r, pred_r, act_r;
  logic [PCW-1:0]   pc_r [DEPTH];
  logic [2:0]       type_r [DEPTH];
  logic [TW:0]      head_r, tail_r;

  logic [DEPTH-1:0] valid_nxt_s, resolved_nxt_s, act_nxt_s;
  logic [TW:0]      head_nxt_s, tail_nxt_s, occ_s;
  logic [TW-1:0]    head_idx_s, tail_idx_s, mis_off_s;
  logic             full_s, res_acc_s, mis_s, alloc_s, train_s, head_act_s;

  assign head_idx_s = head_r[TW-1:0];
  assign tail_idx_s = tail_r[TW-1:0];
  assign occ_s      = tail_r - head_r;
  assign full_s     = (occ_s == FULL_OCC);
  assign res_acc_s  = resValid && valid_r[resTag] && !resolved_r[resTag];
  assign mis_s      = res_acc_s && (resTaken != pred_r[resTag]);
  assign mis_off_s  = resTag - head_idx_s;
  assign predReady  = !reset && !full_s && !mis_s;
  assign predTag    = tail_idx_s;
  assign alloc_s    = predValid && predReady;
  assign occupancy  = occ_s;

  // Queue next state: resolve, then train from the head (sees same-cycle resolve), then squash or allocate
  always_comb begin
    valid_nxt_s    = valid_r;
    resolved_nxt_s = resolved_r;
    act_nxt_s      = act_r;
    head_nxt_s     = head_r;
    tail_nxt_s     = tail_r;
    train_s        = 1'b0;
    head_act_s     = 1'b0;
    if (res_acc_s) begin
      resolved_nxt_s[resTag] = 1'b1;
      act_nxt_s[resTag]      = resTaken;
    end else begin
      resolved_nxt_s = resolved_r;
    end
    head_act_s = act_nxt_s[head_idx_s];
    if (valid_r[head_idx_s] && resolved_nxt_s[head_idx_s]) begin
      train_s                 = 1'b1;
      valid_nxt_s[head_idx_s] = 1'b0;
      head_nxt_s              = head_r + PTR_ONE;
    end else begin
      train_s = 1'b0;
    end
    // Squash is by age relative to the head, so the new tail keeps the head's wrap bit consistent
    if (mis_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((TW'(i) - head_idx_s) > mis_off_s) begin
          valid_nxt_s[i] = 1'b0;
        end else begin
          valid_nxt_s[i] = valid_nxt_s[i];
        end
      end
      tail_nxt_s = head_r + {1'b0, mis_off_s} + PTR_ONE;
    end else if (alloc_s) begin
      valid_nxt_s[tail_idx_s]    = 1'b1;
      resolved_nxt_s[tail_idx_s] = 1'b0;
      tail_nxt_s                 = tail_r + PTR_ONE;
    end else begin
      tail_nxt_s = tail_r;
    end
  end

  // Queue control state
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r    <= '0;
      resolved_r <= '0;
      act_r      <= '0;
      head_r     <= '0;
      tail_r     <= '0;
    end else begin
      valid_r    <= valid_nxt_s;
      resolved_r <= resolved_nxt_s;
      act_r      <= act_nxt_s;
      head_r     <= head_nxt_s;
      tail_r     <= tail_nxt_s;
    end
  end

  // Entry payload, written only on allocation
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      pc_r[tail_idx_s]   <= predPC;
      type_r[tail_idx_s] <= predType;
      pred_r[tail_idx_s] <= predTaken;
    end
  end

  // Registered training and mispredict outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      trainValid     <= 1'b0;
      trainPC        <= '0;
      trainTaken     <= 1'b0;
      trainType      <= 3'd0;
      trainPredicted <= 1'b0;
      mispredict     <= 1'b0;
      mispredictTag  <= '0;
    end else begin
      trainValid <= train_s;
      mispredict <= mis_s;
      if (train_s) begin
        trainPC        <= pc_r[head_idx_s];
        trainTaken     <= head_act_s;
        trainType      <= type_r[head_idx_s];
        trainPredicted <= pred_r[head_idx_s];
      end
      if (mis_s) begin
        mispredictTag <= resTag;
      end
    end
  end

`ifdef BTS_STATS_EN
  // Event counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      statTrained     <= 16'd0;
      statMispredicts <= 16'd0;
    end else begin
      if (train_s) begin
        statTrained <= statTrained + 16'd1;
      end
      if (mis_s) begin
        statMispredicts <= statMispredicts + 16'd1;
      end
    end
  end
`else
  assign statTrained     = 16'd0;
  assign statMispredicts = 16'd0;
`endif

endmodule

// File: tb/tb_branch_training_scheduler.sv
// Self-checking bench for branch_training_scheduler: directed scenarios plus random
// traffic, all checked against an in-order queue model of in-flight branches.
module tb_branch_training_scheduler;

  localparam int DEPTH = 8;
  localparam int PCW   = 32;

  logic clk, reset;
  logic predValid, predTaken, predReady;
  logic [PCW-1:0] predPC;
  logic [2:0] predType, predTag;
  logic resValid, resTaken;
  logic [2:0] resTag;
  logic trainValid, trainTaken, trainPredicted, mispredict;
  logic [PCW-1:0] trainPC;
  logic [2:0] trainType, mispredictTag;
  logic [3:0] occupancy;
  logic [15:0] statTrained, statMispredicts;

  branch_training_scheduler #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk(clk), .reset(reset),
    .predValid(predValid), .predPC(predPC), .predTaken(predTaken), .predType(predType),
    .predReady(predReady), .predTag(predTag),
    .resValid(resValid), .resTag(resTag), .resTaken(resTaken),
    .trainValid(trainValid), .trainPC(trainPC), .trainTaken(trainTaken),
    .trainType(trainType), .trainPredicted(trainPredicted),
    .mispredict(mispredict), .mispredictTag(mispredictTag),
    .occupancy(occupancy), .statTrained(statTrained), .statMispredicts(statMispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [31:0] pc;
    logic [2:0] ty;
    logic       pred;
    logic       res;
    logic       act;
  } entry_t;

  entry_t q[$];          // live branches, oldest first
  int tail_tag;
  int n_train, n_mis;
  int checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef BTS_STATS_EN
    chk("statTrained", {16'd0, statTrained}, {16'd0, 16'(n_train)});
    chk("statMispredicts", {16'd0, statMispredicts}, {16'd0, 16'(n_mis)});
`else
    chk("statTrained", {16'd0, statTrained}, 32'd0);
    chk("statMispredicts", {16'd0, statMispredicts}, 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1; predValid = 1'b0; resValid = 1'b0;
    predPC = '0; predTaken = 1'b0; predType = 3'd0; resTag = 3'd0; resTaken = 1'b0;
    #2;
    chk("rst_predReady", {31'd0, predReady}, 32'd0);
    @(posedge clk); #1;
    q.delete(); tail_tag = 0; n_train = 0; n_mis = 0;
    chk("rst_trainValid", {31'd0, trainValid}, 32'd0);
    chk("rst_trainPC", trainPC, 32'd0);
    chk("rst_trainTaken", {31'd0, trainTaken}, 32'd0);
    chk("rst_trainType", {29'd0, trainType}, 32'd0);
    chk("rst_trainPredicted", {31'd0, trainPredicted}, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_mispredictTag", {29'd0, mispredictTag}, 32'd0);
    chk("rst_occupancy", {28'd0, occupancy}, 32'd0);
    check_stats();
    reset = 1'b0;
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registered outputs
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic pt, input logic [2:0] ty,
                       input logic rv, input logic [2:0] rt, input logic rtk);
    int k;
    bit acc, mis, tr, ready;
    entry_t t;
    predValid = pv; predPC = pc; predTaken = pt; predType = ty;
    resValid = rv; resTag = rt; resTaken = rtk;
    k = -1;
    if (rv) foreach (q[i]) if (q[i].tag == int'(rt) && !q[i].res) k = i;
    acc = 1'b0; mis = 1'b0;
    if (k >= 0) begin acc = 1'b1; mis = (rtk != q[k].pred); end
    ready = (q.size() < DEPTH) && !mis;
    #2;
    chk("predReady", {31'd0, predReady}, {31'd0, ready});
    chk("predTag", {29'd0, predTag}, tail_tag);
    if (acc) begin q[k].res = 1'b1; q[k].act = rtk; end
    if (mis) while (q.size() > k + 1) void'(q.pop_back());
    tr = 1'b0;
    if (q.size() > 0) tr = q[0].res;
    if (tr) t = q.pop_front();
    if (mis) tail_tag = (int'(rt) + 1) % DEPTH;
    else if (pv && ready) begin
      q.push_back('{tag: tail_tag, pc: pc, ty: ty, pred: pt, res: 1'b0, act: 1'b0});
      tail_tag = (tail_tag + 1) % DEPTH;
    end
    if (tr) n_train++;
    if (mis) n_mis++;
    @(posedge clk); #1;
    chk("trainValid", {31'd0, trainValid}, {31'd0, tr});
    if (tr) begin
      chk("trainPC", trainPC, t.pc);
      chk("trainTaken", {31'd0, trainTaken}, {31'd0, t.act});
      chk("trainType", {29'd0, trainType}, {29'd0, t.ty});
      chk("trainPredicted", {31'd0, trainPredicted}, {31'd0, t.pred});
    end
    chk("mispredict", {31'd0, mispredict}, {31'd0, mis});
    if (mis) chk("mispredictTag", {29'd0, mispredictTag}, {29'd0, rt});
    chk("occupancy", {28'd0, occupancy}, q.size());
    check_stats();
  endtask

  task automatic alloc(input logic [31:0] pc, input logic pt);
    cycle(1'b1, pc, pt, 3'd1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic resolve(input logic [2:0] rt, input logic rtk);
    cycle(1'b0, 32'd0, 1'b0, 3'd0, 1'b1, rt, rtk);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    logic pv, pt, rv, rtk;
    logic [31:0] pc;
    logic [2:0] ty, rt;
    entry_t e;
    checks = 0; errors = 0;

    // Ordered flow
    do_reset();
    alloc(32'h100, 1'b1); alloc(32'h104, 1'b1); alloc(32'h108, 1'b1);
    resolve(3'd0, 1'b1); resolve(3'd1, 1'b1); resolve(3'd2, 1'b1);
    idle();

    // Out-of-order resolution
    do_reset();
    alloc(32'h100, 1'b1); alloc(32'h104, 1'b1); alloc(32'h108, 1'b0);
    resolve(3'd2, 1'b0); resolve(3'd1, 1'b1); resolve(3'd0, 1'b1);
    idle(); idle(); idle();

    // Mispredict squash
    do_reset();
    for (int i = 0; i < 5; i++) alloc(32'h300 + 32'(4 * i), 1'b1);
    resolve(3'd1, 1'b0);
    resolve(3'd3, 1'b1); resolve(3'd4, 1'b0);
    alloc(32'h400, 1'b0);
    resolve(3'd0, 1'b1); idle(); idle();

    // Full and wrap with continuous allocate/train
    do_reset();
    for (int i = 0; i < 9; i++) alloc(32'h200 + 32'(4 * i), i[0]);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 32'h800 + 32'(4 * i), i[1], 3'(i), 1'b1, 3'(q[0].tag), q[0].pred);

    // Train and mispredict on the only entry while fetch tries to allocate
    do_reset();
    alloc(32'h500, 1'b1);
    cycle(1'b1, 32'h504, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0);
    idle();

    // Reset mid-run with resolved entries waiting behind the head
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'h600 + 32'(4 * i), 1'b1);
    resolve(3'd1, 1'b1); resolve(3'd2, 1'b1);
    do_reset();
    idle(); idle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      pv = ($urandom_range(0, 3) != 0);
      pc = $urandom;
      pt = 1'($urandom_range(0, 1));
      ty = 3'($urandom_range(0, 7));
      rv = 1'($urandom_range(0, 1));
      if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
        e = q[$urandom_range(0, q.size() - 1)];
        rt = 3'(e.tag);
        rtk = ($urandom_range(0, 5) == 0) ? !e.pred : e.pred;
      end else begin
        rt = 3'($urandom_range(0, 7));
        rtk = 1'($urandom_range(0, 1));
      end
      cycle(pv, pc, pt, ty, rv, rt, rtk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_training_scheduler.md
# branch_training_scheduler

Sequences training of the adaptive branch predictor. Every prediction issued at fetch is held in an in-order in-flight queue. Resolutions arriving from execute, possibly out of order and tagged, are matched to their queue entries. The predictor training port then receives exactly one in-program-order update per cycle, and a mispredict pulse squashes younger in-flight branches.

## Interface
- DEPTH, 8: in-flight entries; power of two, 2..64; TW = log2(DEPTH)
- PCW, 32: PC width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- predValid  in  1  fetch issues a predicted branch this cycle
- predPC  in  PCW  branch PC
- predTaken  in  1  direction predicted by predictor
- predType  in  3  branch type
- predReady  out  1  entry available; allocation happens iff predValid && predReady
- predTag  out  TW  tag of the allocated entry (tail index), valid same cycle
- resValid  in  1  execute resolved a branch
- resTag  in  TW  tag of the resolved branch
- resTaken  in  1  actual direction
- trainValid  out  1  one-cycle training strobe to predictor branchResolved
- trainPC  out  PCW  PC of the trained branch (predictor resolvedPC)
- trainTaken  out  1  actual direction (predictor actualTaken)
- trainType  out  3  branch type of the trained entry
- trainPredicted  out  1  direction originally predicted
- mispredict  out  1  one-cycle pulse, resolution disagreed with prediction
- mispredictTag  out  TW  tag of the mispredicted branch, valid with mispredict
- occupancy  out  TW+1  live entries, 0..DEPTH
- statTrained  out  16  trained-entry count
- statMispredicts  out  16  mispredict count

## Operation
- Circular buffer. Each entry holds: valid, resolved, PC, type, predicted, actual.
- Head and tail pointers are TW+1 bits with a wrap bit. occupancy = tail - head, modulo 2^(TW+1).
- Full is occupancy == DEPTH.
- predReady = !reset && !full && !(mispredict detected this cycle). This is a combinational path from resValid/resTag/resTaken.
- Allocate: write the entry at the tail with valid=1 and resolved=0, then increment the tail.
- Resolve: if resValid and entry[resTag] is valid and unresolved, set resolved=1 and actual=resTaken. In all other cases (stale or duplicate tag) the resolution is ignored with no other effect.
- Mispredict detection: an accepted resolution where resTaken != predicted.
- On mispredict:
  - Invalidate all entries strictly younger than resTag.
  - Set tail to resTag+1, keeping the wrap bit consistent with the head.
  - The resolved entry itself stays and is trained normally.
- Train: each cycle, if the head entry is valid and resolved, using the post-resolve state (same-cycle bypass of resValid on the head), then:
  - Register the train* outputs.
  - Assert trainValid for the next cycle.
  - Clear entry.valid and increment the head.
- At most one training per cycle, always from the head.
- Younger resolved entries wait for the head.
- All three actions (allocate, resolve, train) may occur in one cycle.
- Allocate and mispredict in the same cycle: the mispredict wins, because predReady is low.
- Train and mispredict on the head in the same cycle: both occur. The head advances, the tail becomes head+1, and occupancy ends at 0.
- Stats: each counter increments by 1 per trainValid or mispredict, and wraps at 16 bits.

## Timing
- predTag and predReady are combinational within the cycle.
- Resolution of the head at cycle N: trainValid is high during cycle N+1 only.
- Mispredict detected at cycle N: the mispredict pulse is seen in cycle N+1. Squash and tail update occur at the N/N+1 edge.
- Sustained throughput: one allocation plus one training per cycle.
- Reset: all entries invalid, head = tail = 0.
- Reset values: trainValid=0, trainPC=0, trainTaken=0, trainType=0, trainPredicted=0, mispredict=0, mispredictTag=0, occupancy=0, stats=0.
- predReady is 0 while reset is high and 1 in the first cycle after reset.
- Reset asserted mid-operation discards all in-flight entries. No training strobe is emitted in the following cycle.

## Configuration
- BTS_STATS_EN defined: statTrained and statMispredicts counters are implemented as described.
- BTS_STATS_EN undefined: both outputs are tied to 0 and no counter flops are synthesized.
- Queue behaviour is identical in both cases.

## Test plan
- Ordered flow:
  - Stimulus: allocate 3 branches (PC 0x100/0x104/0x108, predTaken=1), then resolve tags 0, 1, 2 taken, one per cycle.
  - Required: three trainValid pulses, PCs in order, each 1 cycle after its resolve; no mispredict; occupancy returns to 0.
- Out-of-order:
  - Stimulus: allocate tags 0..2, then resolve 2, then 1, then 0.
  - Required: no trainValid until tag 0 resolves; then trainValid on 3 consecutive cycles for PCs 0x100, 0x104, 0x108.
- Mispredict squash:
  - Stimulus: allocate 5 (tags 0..4), then resolve tag 1 with resTaken=0 against predicted=1.
  - Required: mispredict=1 with mispredictTag=1 next cycle; occupancy=2; next predTag=2; later resolutions for tags 3 and 4 are ignored.
- Full/wrap:
  - Stimulus: allocate 8, then resolve and train the head each cycle while allocating continuously for 20 cycles.
  - Required: predReady is 0 only when 8 entries are live; tags wrap 7 -> 0; no lost or duplicated trainPC.
- Simultaneous:
  - Stimulus: head tag 0 is the only entry; in one cycle, mispredict-resolve tag 0 while predValid=1.
  - Required: predReady=0 that cycle; trainValid and mispredict both high next cycle; occupancy=0.
- Reset mid-run:
  - Stimulus: 4 entries live, 2 resolved; assert reset for 1 cycle.
  - Required: no trainValid afterwards; occupancy=0; stats=0 (with BTS_STATS_EN).
